data_unbuffer: RTL and testbench
================================

// Module: data_unbuffer
// PURPOSE
//  Inverse of the data_buffer compaction path. data_buffer packs the valid lanes of a
//  16-lane frame into consecutive outputs 0..N-1. This block receives those N packed
//  words serially and scatters them back to their original lane positions, using the
//  frame's valids mask. Sits on the receive side, downstream of the packed link.
// PARAMETERS
//  NUM_LANES  16  lane count; also the width of the valids mask
//  DATA_W     32  width of each lane word
// PORTS
//  clk          in   1                 system clock, rising edge
//  rst_n        in   1                 asynchronous active-low reset
//  flush        in   1                 synchronous abort of the current frame
//  mask_valid   in   1                 valids mask offered
//  mask_ready   out  1                 block accepts a mask (IDLE only)
//  mask_in      in   NUM_LANES         valids mask of the next frame
//  word_valid   in   1                 packed word offered
//  word_ready   out  1                 block accepts a word (FILL only)
//  word_in      in   DATA_W            packed word, lowest destination lane first
//  out_valid    out  1                 expanded frame available
//  out_ready    in   1                 consumer takes the frame
//  out_mask     out  NUM_LANES         mask of the held frame
//  lanes_out    out  NUM_LANES*DATA_W  lane k = bits [k*DATA_W +: DATA_W]
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, lanes_out=0, out_mask=0, out_valid=0,
//    word_ready=0, mask_ready=1 once reset is released. Reset mid-frame discards the frame.
//  - FSM IDLE -> FILL -> HOLD -> IDLE. mask_ready, word_ready and out_valid are decoded
//    from state only. They never depend combinationally on the *_valid or *_ready inputs.
//  - IDLE: when mask_valid&&mask_ready, latch mask_in into out_mask and remaining mask,
//    and clear all lane registers to 0. If mask_in==0, go to HOLD (empty frame).
//    Otherwise go to FILL with cursor = index of the lowest set bit.
//  - FILL: when word_valid&&word_ready, write lane[cursor]<=word_in, clear bit cursor
//    from remaining, and set cursor to the next lowest set bit.
//    When the consumed bit was the last one, go to HOLD.
//  - HOLD: out_valid=1. lanes_out and out_mask stay stable until out_ready=1, then go to
//    IDLE. Lanes not set in the mask read 0.
//  - Latency: out_valid rises the cycle after the last word handshake, or the cycle after
//    the mask handshake for a zero mask. There is no IDLE bypass: a new mask is accepted
//    no earlier than the cycle after the out handshake.
//    Frame cost = popcount(mask)+2 cycles.
//  - word_valid outside FILL is ignored and no word is consumed.
//    mask_valid outside IDLE is ignored.
//  - flush=1: go to IDLE next cycle from any state. lanes_out and out_mask are cleared to 0.
//    Any handshake in the same cycle is void. flush overrides out_ready and the last-word
//    transition. flush in IDLE also voids that cycle's mask handshake.
//  - Word order is strictly ascending lane index, matching data_buffer, where output i
//    carries the i-th set bit. No reordering and no error detection is done.
//  - cursor is $clog2(NUM_LANES) bits wide. remaining==0 is never reached inside FILL.
// STRUCTURE
//  - Shared include data_buffer_defs.vh: NUM_LANES, DATA_W, the state encodings
//    (IDLE=2'd0, FILL=2'd1, HOLD=2'd2) and a CURSOR_W localparam.
//    data_buffer's encoder uses the same include.
//  - Sub-module lane_priority_enc: combinational lowest-set-bit index plus any-set flag
//    over NUM_LANES bits. It computes cursor from remaining (or from mask_in in IDLE).
//  - Top level holds the FSM, the remaining-mask register, and NUM_LANES DATA_W-bit lane
//    registers, each with a write-enable decoded from cursor.
// TESTING
//  1. mask=16'h0001, word=32'hA5A5_0001.
//     -> lane0=A5A50001, lanes 1-15=0, out_valid in cycle 2 after the mask handshake,
//        out_mask=0001.
//  2. mask=16'h8421, words 11,22,33,44.
//     -> lane0=11, lane5=22, lane10=33, lane15=44, all others 0.
//     Repeat through data_buffer->data_unbuffer round trip: all valid lanes match.
//  3. mask=16'hFFFF, word_valid toggling every other cycle, words 0..15.
//     -> lane k=k, and out_valid stays 0 until the 16th word is accepted.
//  4. mask=16'h0000.
//     -> out_valid on the next cycle, lanes_out=0, out_mask=0, and no word is consumed.
//  5. Hold out_ready=0 for 10 cycles in HOLD.
//     -> lanes_out stable, mask_ready=0, word_ready=0.
//     Then out_ready=1 -> mask_ready=1 on the next cycle.
//  6. mask=16'h00FF, flush after 3 words -> IDLE next cycle, out_valid never asserts,
//     lanes_out=0. Repeat with rst_n pulsed low mid-FILL -> same result.

Source files
------------

// File: rtl/data_unbuffer_pkg.sv
// rtl/data_unbuffer_pkg.sv - shared constants and state encodings for the lane scatter path
package data_unbuffer_pkg;

  // Default geometry, shared with the data_buffer compaction side
  localparam int DU_NUM_LANES = 16;
  localparam int DU_DATA_W    = 32;
  localparam int DU_CURSOR_W  = $clog2(DU_NUM_LANES);

  typedef logic [1:0] state_t;

  // Encodings match the data_buffer encoder so state can be compared across blocks
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/data_unbuffer_if.sv
// rtl/data_unbuffer_if.sv - mask, packed-word and expanded-frame handshakes
interface data_unbuffer_if
  import data_unbuffer_pkg::*;
#(
  parameter int NUM_LANES = DU_NUM_LANES,
  parameter int DATA_W    = DU_DATA_W
);
  logic                        mask_valid;
  logic                        mask_ready;
  logic [NUM_LANES-1:0]        mask_in;
  logic                        word_valid;
  logic                        word_ready;
  logic [DATA_W-1:0]           word_in;
  logic                        out_valid;
  logic                        out_ready;
  logic [NUM_LANES-1:0]        out_mask;
  logic [NUM_LANES*DATA_W-1:0] lanes_out;

  // Producer/consumer side of the link
  modport master (
    output mask_valid, mask_in, word_valid, word_in, out_ready,
    input  mask_ready, word_ready, out_valid, out_mask, lanes_out
  );

  // The unbuffer block itself
  modport slave (
    input  mask_valid, mask_in, word_valid, word_in, out_ready,
    output mask_ready, word_ready, out_valid, out_mask, lanes_out
  );
endinterface

// File: rtl/data_unbuffer_lane_priority_enc.sv
// rtl/data_unbuffer_lane_priority_enc.sv - lowest-set-bit index and any-set flag
module lane_priority_enc #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/data_unbuffer.sv
// rtl/data_unbuffer.sv - scatters serially received packed words back to their lanes
module data_unbuffer
  import data_unbuffer_pkg::*;
#(
  parameter int NUM_LANES = DU_NUM_LANES,
  parameter int DATA_W    = DU_DATA_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  data_unbuffer_if.slave  bus
);

  localparam int CURSOR_W = $clog2(NUM_LANES);

  state_t                      state;
  logic [NUM_LANES-1:0]        remaining;
  logic [NUM_LANES-1:0]        out_mask_q;
  logic [NUM_LANES-1:0]        enc_vec;
  logic [NUM_LANES-1:0]        cur_onehot;
  logic [NUM_LANES-1:0]        rem_after;
  logic [CURSOR_W-1:0]         cursor;
  logic                        enc_any;
  logic                        mask_fire;
  logic                        word_fire;
  logic [DATA_W-1:0]           lane_q [NUM_LANES];
  logic [NUM_LANES*DATA_W-1:0] lanes_flat;

  // In IDLE the encoder looks at the incoming mask so a zero mask is seen directly;
  // in FILL it tracks the lanes still waiting for a word.
  assign enc_vec = (state == ST_IDLE) ? bus.mask_in : remaining;

  lane_priority_enc #(
    .N (NUM_LANES),
    .W (CURSOR_W)
  ) u_enc (
    .vec (enc_vec),
    .idx (cursor),
    .any (enc_any)
  );

  assign cur_onehot = {{(NUM_LANES-1){1'b0}}, 1'b1} << cursor;
  assign rem_after  = remaining & ~cur_onehot;

  // flush voids any handshake that would otherwise land in the same cycle
  assign mask_fire = bus.mask_valid && (state == ST_IDLE) && !flush;
  assign word_fire = bus.word_valid && (state == ST_FILL) && !flush;

  // Handshake outputs come from state alone
  assign bus.mask_ready = (state == ST_IDLE);
  assign bus.word_ready = (state == ST_FILL);
  assign bus.out_valid  = (state == ST_HOLD);
  assign bus.out_mask   = out_mask_q;
  assign bus.lanes_out  = lanes_flat;

  // Frame sequencing plus the remaining-lane and captured-mask registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      out_mask_q <= '0;
    end else if (flush) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      out_mask_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mask_fire) begin
            out_mask_q <= bus.mask_in;
            remaining  <= bus.mask_in;
            state      <= enc_any ? ST_FILL : ST_HOLD;
          end
        end
        ST_FILL: begin
          if (word_fire) begin
            remaining <= rem_after;
            if (rem_after == '0) begin
              state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    // Lane k clears on a new frame or flush and loads when the cursor points at it
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lane_q[k] <= '0;
      end else if (flush || mask_fire) begin
        lane_q[k] <= '0;
      end else if (word_fire && (cursor == CURSOR_W'(k))) begin
        lane_q[k] <= bus.word_in;
      end
    end

    assign lanes_flat[k*DATA_W +: DATA_W] = lane_q[k];
  end

endmodule

// File: tb/tb_data_unbuffer.sv
// tb/tb_data_unbuffer.sv - directed self-checking bench for data_unbuffer
module tb_data_unbuffer;
  import data_unbuffer_pkg::*;

  localparam int NL = 16;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  int n_pass  = 0;
  int n_total = 0;

  logic [NL*DW-1:0] exp_lanes;

  always #5 clk = ~clk;

  data_unbuffer_if bus ();

  data_unbuffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  task automatic idle_inputs();
    bus.mask_valid = 1'b0;
    bus.mask_in    = '0;
    bus.word_valid = 1'b0;
    bus.word_in    = '0;
    bus.out_ready  = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic send_mask(input logic [NL-1:0] m);
    int t;
    t = 0;
    bus.mask_valid = 1'b1;
    bus.mask_in    = m;
    @(negedge clk);
    while (!bus.mask_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.mask_ready) begin
      n_total++;
      $display("FAIL mask_timeout: mask_ready=%0b, required 1", bus.mask_ready);
    end
    @(posedge clk);
    #1;
    bus.mask_valid = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    int t;
    t = 0;
    bus.word_valid = 1'b1;
    bus.word_in    = w;
    @(negedge clk);
    while (!bus.word_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.word_ready) begin
      n_total++;
      $display("FAIL word_timeout: word_ready=%0b, required 1", bus.word_ready);
    end
    @(posedge clk);
    #1;
    bus.word_valid = 1'b0;
  endtask

  task automatic take_out();
    int t;
    t = 0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    while (!bus.out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.out_valid) begin
      n_total++;
      $display("FAIL out_timeout: out_valid=%0b, required 1", bus.out_valid);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b, required 0", bus.out_valid);
    else n_pass++;
    n_total++;
    if (bus.word_ready !== 1'b0) $display("FAIL reset_word_ready: got %0b, required 0", bus.word_ready);
    else n_pass++;
    n_total++;
    if (bus.mask_ready !== 1'b1) $display("FAIL reset_mask_ready: got %0b, required 1", bus.mask_ready);
    else n_pass++;
    n_total++;
    if (bus.lanes_out !== '0) $display("FAIL reset_lanes: got %h, required 0", bus.lanes_out);
    else n_pass++;
    n_total++;
    if (bus.out_mask !== 16'h0000) $display("FAIL reset_out_mask: got %h, required 0000", bus.out_mask);
    else n_pass++;
  endtask

  task automatic test_single_lane();
    send_mask(16'h0001);
    bus.word_valid = 1'b1;
    bus.word_in    = 32'hA5A5_0001;
    @(negedge clk);
    n_total++;
    if (bus.out_valid !== 1'b0 || bus.word_ready !== 1'b1)
      $display("FAIL single_fill_state: out_valid=%0b word_ready=%0b, required 0/1",
               bus.out_valid, bus.word_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    bus.word_valid = 1'b0;
    n_total++;
    if (bus.out_valid !== 1'b1) $display("FAIL single_latency: out_valid=%0b, required 1", bus.out_valid);
    else n_pass++;
    exp_lanes = '0;
    exp_lanes[0 +: DW] = 32'hA5A5_0001;
    n_total++;
    if (bus.lanes_out !== exp_lanes) $display("FAIL single_lanes: got %h, required %h", bus.lanes_out, exp_lanes);
    else n_pass++;
    n_total++;
    if (bus.out_mask !== 16'h0001) $display("FAIL single_mask: got %h, required 0001", bus.out_mask);
    else n_pass++;
    take_out();
  endtask

  task automatic test_sparse();
    send_mask(16'h8421);
    send_word(32'h11);
    send_word(32'h22);
    send_word(32'h33);
    send_word(32'h44);
    exp_lanes = '0;
    exp_lanes[0*DW  +: DW] = 32'h11;
    exp_lanes[5*DW  +: DW] = 32'h22;
    exp_lanes[10*DW +: DW] = 32'h33;
    exp_lanes[15*DW +: DW] = 32'h44;
    n_total++;
    if (bus.out_valid !== 1'b1) $display("FAIL sparse_valid: got %0b, required 1", bus.out_valid);
    else n_pass++;
    n_total++;
    if (bus.lanes_out !== exp_lanes) $display("FAIL sparse_lanes: got %h, required %h", bus.lanes_out, exp_lanes);
    else n_pass++;
    n_total++;
    if (bus.out_mask !== 16'h8421) $display("FAIL sparse_mask: got %h, required 8421", bus.out_mask);
    else n_pass++;
    take_out();
  endtask

  task automatic test_full_toggle();
    logic early;
    early = 1'b0;
    send_mask(16'hFFFF);
    for (int k = 0; k < NL; k++) begin
      send_word(DW'(k));
      if (k < NL - 1) begin
        if (bus.out_valid !== 1'b0) early = 1'b1;
        @(posedge clk);
        #1;
        if (bus.out_valid !== 1'b0) early = 1'b1;
      end
    end
    n_total++;
    if (early) $display("FAIL full_early_valid: out_valid rose before word 16, required 0");
    else n_pass++;
    n_total++;
    if (bus.out_valid !== 1'b1) $display("FAIL full_valid: got %0b, required 1", bus.out_valid);
    else n_pass++;
    exp_lanes = '0;
    for (int k = 0; k < NL; k++) exp_lanes[k*DW +: DW] = DW'(k);
    n_total++;
    if (bus.lanes_out !== exp_lanes) $display("FAIL full_lanes: got %h, required %h", bus.lanes_out, exp_lanes);
    else n_pass++;
    take_out();
  endtask

  task automatic test_zero_mask();
    bus.word_valid = 1'b1;
    bus.word_in    = 32'hDEAD_BEEF;
    send_mask(16'h0000);
    n_total++;
    if (bus.out_valid !== 1'b1) $display("FAIL zero_valid: got %0b, required 1", bus.out_valid);
    else n_pass++;
    n_total++;
    if (bus.lanes_out !== '0) $display("FAIL zero_lanes: got %h, required 0", bus.lanes_out);
    else n_pass++;
    n_total++;
    if (bus.out_mask !== 16'h0000) $display("FAIL zero_mask: got %h, required 0000", bus.out_mask);
    else n_pass++;
    n_total++;
    if (bus.word_ready !== 1'b0) $display("FAIL zero_word_ready: got %0b, required 0", bus.word_ready);
    else n_pass++;
    take_out();
    bus.word_valid = 1'b0;
  endtask

  task automatic test_hold_stall();
    logic bad;
    bad = 1'b0;
    send_mask(16'h0003);
    send_word(32'hAAAA_0000);
    send_word(32'hBBBB_1111);
    exp_lanes = '0;
    exp_lanes[0*DW +: DW] = 32'hAAAA_0000;
    exp_lanes[1*DW +: DW] = 32'hBBBB_1111;
    bus.mask_valid = 1'b1;
    bus.mask_in    = 16'h00F0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.lanes_out !== exp_lanes || bus.mask_ready !== 1'b0 ||
          bus.word_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_mask !== 16'h0003)
        bad = 1'b1;
    end
    bus.mask_valid = 1'b0;
    n_total++;
    if (bad) $display("FAIL hold_stable: outputs moved during stall, required stable HOLD");
    else n_pass++;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    n_total++;
    if (bus.mask_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL hold_release: mask_ready=%0b out_valid=%0b, required 1/0",
               bus.mask_ready, bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_round_trip();
    logic [DW-1:0] src [NL];
    logic [NL-1:0] m;
    m = 16'h1248;
    exp_lanes = '0;
    for (int k = 0; k < NL; k++) begin
      src[k] = {16'hC0DE, 16'(k)};
      if (m[k]) exp_lanes[k*DW +: DW] = src[k];
    end
    send_mask(m);
    for (int k = 0; k < NL; k++) begin
      if (m[k]) send_word(src[k]);
    end
    n_total++;
    if (bus.lanes_out !== exp_lanes) $display("FAIL round_trip_lanes: got %h, required %h", bus.lanes_out, exp_lanes);
    else n_pass++;
    take_out();
    n_total++;
    if (bus.mask_ready !== 1'b1) $display("FAIL round_trip_next_mask: got %0b, required 1", bus.mask_ready);
    else n_pass++;
  endtask

  task automatic test_flush();
    logic rose;
    rose = 1'b0;
    send_mask(16'h00FF);
    send_word(32'h1);
    send_word(32'h2);
    send_word(32'h3);
    flush          = 1'b1;
    bus.word_valid = 1'b1;
    bus.word_in    = 32'h99;
    @(posedge clk);
    #1;
    flush          = 1'b0;
    bus.word_valid = 1'b0;
    n_total++;
    if (bus.mask_ready !== 1'b1 || bus.word_ready !== 1'b0)
      $display("FAIL flush_state: mask_ready=%0b word_ready=%0b, required 1/0",
               bus.mask_ready, bus.word_ready);
    else n_pass++;
    n_total++;
    if (bus.lanes_out !== '0 || bus.out_mask !== 16'h0000)
      $display("FAIL flush_clear: lanes=%h mask=%h, required 0/0", bus.lanes_out, bus.out_mask);
    else n_pass++;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) rose = 1'b1;
    end
    n_total++;
    if (rose) $display("FAIL flush_no_valid: out_valid rose after flush, required 0");
    else n_pass++;
    @(posedge clk);
    #1;
    bus.mask_valid = 1'b1;
    bus.mask_in    = 16'h0005;
    flush          = 1'b1;
    @(posedge clk);
    #1;
    flush          = 1'b0;
    bus.mask_valid = 1'b0;
    n_total++;
    if (bus.mask_ready !== 1'b1 || bus.out_mask !== 16'h0000)
      $display("FAIL flush_idle_void: mask_ready=%0b mask=%h, required 1/0000",
               bus.mask_ready, bus.out_mask);
    else n_pass++;
  endtask

  task automatic test_reset_mid_fill();
    logic rose;
    rose = 1'b0;
    send_mask(16'h00FF);
    send_word(32'h1);
    send_word(32'h2);
    send_word(32'h3);
    rst_n = 1'b0;
    #2;
    n_total++;
    if (bus.lanes_out !== '0 || bus.out_mask !== 16'h0000 ||
        bus.mask_ready !== 1'b1 || bus.word_ready !== 1'b0)
      $display("FAIL reset_mid_fill: lanes=%h mask=%h mask_ready=%0b word_ready=%0b, required 0/0/1/0",
               bus.lanes_out, bus.out_mask, bus.mask_ready, bus.word_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) rose = 1'b1;
    end
    n_total++;
    if (rose) $display("FAIL reset_no_valid: out_valid rose after reset, required 0");
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_recovery();
    send_mask(16'h0002);
    send_word(32'hBEEF);
    exp_lanes = '0;
    exp_lanes[1*DW +: DW] = 32'hBEEF;
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.lanes_out !== exp_lanes)
      $display("FAIL recovery_frame: valid=%0b lanes=%h, required 1/%h",
               bus.out_valid, bus.lanes_out, exp_lanes);
    else n_pass++;
    take_out();
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_sparse();
    test_full_toggle();
    test_zero_mask();
    test_hold_stall();
    test_round_trip();
    test_flush();
    test_reset_mid_fill();
    test_recovery();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
